pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) of the multicore datapath. It replaces fixed per-stage latch interfaces that use a global enable/flush with a generic WIDTH-bit payload queue of DEPTH entries. Stage control is a valid/ready handshake, with a synchronous flush for branch/jump squash. Stages pack their control and data fields into one payload vector, and stalls arise from backpressure instead of a shared enable.

---
 rtl/cpu_types_pkg.sv | 67 ++++++
 rtl/pipe_slot_ram.sv | 29 ++
 rtl/pipe_stage_elastic.sv | 108 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the CPU pipeline plus sizing helpers for the
// elastic inter-stage registers (instances set WIDTH = $bits(<stage struct>)).
package cpu_types_pkg;

  localparam int unsigned PIPE_MAX_DEPTH = 4;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  funct_t;

  typedef enum logic [6:0] {
    OP_R   = 7'b0110011,
    OP_I   = 7'b0010011,
    OP_LD  = 7'b0000011,
    OP_ST  = 7'b0100011,
    OP_BR  = 7'b1100011,
    OP_JAL = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } aluop_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } ifid_t;

  typedef struct packed {
    word_t       pc;
    word_t       rs1_val;
    word_t       rs2_val;
    word_t       imm;
    logic [4:0]  rd;
    aluop_t      aluop;
    opcode_t     opcode;
    funct_t      funct;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
  } idex_t;

  typedef struct packed {
    word_t       alu_result;
    word_t       rs2_val;
    logic [4:0]  rd;
    funct_t      funct;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } exmem_t;

  typedef struct packed {
    word_t       alu_result;
    word_t       mem_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
  } memwb_t;

  // A single-entry queue still needs a one-bit pointer to keep port widths legal.
  function automatic int unsigned pipe_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_slot_ram.sv
// DEPTH x WIDTH payload storage for the elastic pipeline register:
// one write port, one asynchronous read port, cleared on reset.
module pipe_slot_ram #(
  parameter int unsigned WIDTH = 160,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q <= '{default: '0};
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with synchronous squash.
// Optional stall/flush statistics counters are built when PIPE_STAT_EN is defined.
module pipe_stage_elastic
  import cpu_types_pkg::*;
#(
  parameter int unsigned WIDTH = 160,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAT_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
`endif
);

  localparam int unsigned PTR_W = pipe_ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Handshake flags come from registered count only, so out_ready never reaches in_ready.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign occupancy = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  pipe_slot_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_slots (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en_i   (push & ~flush),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (out_data)
  );

`ifdef PIPE_STAT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        flush_discard;

  // A head popped during the flush was consumed, so only leftovers make it a discarding flush.
  assign flush_discard = flush & out_valid & ~(pop & (count_q == CNT_W'(1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_discard && flush_cnt_q != '1)            flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a DEPTH=2 and a DEPTH=3 instance
// share clock and reset; each task drives one scenario and checks inline.
module tb_pipe_stage_elastic;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        f2, iv2, ir2, ov2, or2;
  logic [31:0] id2, od2;
  logic [1:0]  occ2;
  logic        f3, iv3, ir3, ov3, or3;
  logic [31:0] id3, od3;
  logic [1:0]  occ3;
`ifdef PIPE_STAT_EN
  logic [31:0] sc2, fc2, sc3, fc3;
`endif

  always #5 CLK = ~CLK;

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .CLK(CLK), .RST(RST), .flush(f2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(occ2)
`ifdef PIPE_STAT_EN
    , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
  );

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .CLK(CLK), .RST(RST), .flush(f3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(occ3)
`ifdef PIPE_STAT_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  task automatic do_reset();
    RST = 1'b1;
    f2 = 0; iv2 = 0; id2 = '0; or2 = 0;
    f3 = 0; iv3 = 0; id3 = '0; or3 = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    n_chk++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready2: got %b want 1", ir2); end
    n_chk++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid2: got %b want 0", ov2); end
    n_chk++; if (od2 !== 32'h0) begin n_fail++; $display("FAIL rst_out_data2: got %h want 0", od2); end
    n_chk++; if (occ2 !== 2'd0) begin n_fail++; $display("FAIL rst_occ2: got %0d want 0", occ2); end
    n_chk++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready3: got %b want 1", ir3); end
    n_chk++; if (occ3 !== 2'd0) begin n_fail++; $display("FAIL rst_occ3: got %0d want 0", occ3); end
`ifdef PIPE_STAT_EN
    n_chk++; if (sc2 !== 32'd0 || sc3 !== 32'd0) begin n_fail++; $display("FAIL rst_stall: got %0d/%0d want 0/0", sc2, sc3); end
    n_chk++; if (fc2 !== 32'd0 || fc3 !== 32'd0) begin n_fail++; $display("FAIL rst_flush_cnt: got %0d/%0d want 0/0", fc2, fc3); end
`endif
  endtask

  task automatic test_latency();
    iv2 = 1; id2 = 32'h11; or2 = 1;
    #1;
    n_chk++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL lat_no_bypass: got %b want 0", ov2); end
    @(negedge CLK);
    iv2 = 0;
    n_chk++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b want 1", ov2); end
    n_chk++; if (od2 !== 32'h11) begin n_fail++; $display("FAIL lat_data: got %h want 11", od2); end
    n_chk++; if (occ2 !== 2'd1) begin n_fail++; $display("FAIL lat_occ: got %0d want 1", occ2); end
    @(negedge CLK);
    n_chk++; if (ov2 !== 1'b0 || occ2 !== 2'd0) begin n_fail++; $display("FAIL lat_drain: got valid=%b occ=%0d want 0/0", ov2, occ2); end
    or2 = 0;
  endtask

  task automatic test_back_to_back();
    or2 = 1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        n_chk++; if (ov2 !== 1'b1 || od2 !== 32'(i - 1)) begin n_fail++; $display("FAIL b2b_out[%0d]: got valid=%b data=%h want 1/%h", i - 1, ov2, od2, 32'(i - 1)); end
      end
      if (i < 8) begin
        n_chk++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ir2); end
        iv2 = 1; id2 = 32'(i);
      end else begin
        iv2 = 0;
      end
      @(negedge CLK);
    end
    n_chk++; if (ov2 !== 1'b0 || occ2 !== 2'd0) begin n_fail++; $display("FAIL b2b_empty: got valid=%b occ=%0d want 0/0", ov2, occ2); end
    or2 = 0;
  endtask

  task automatic test_fill_wrap();
    // Leave both pointers at 1 so the fills below wrap mid-round.
    iv3 = 1; id3 = 32'hBEEF; or3 = 1;
    @(negedge CLK);
    iv3 = 0;
    n_chk++; if (od3 !== 32'hBEEF) begin n_fail++; $display("FAIL wrap_pre: got %h want beef", od3); end
    @(negedge CLK);
    or3 = 0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        n_chk++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL wrap_ready r%0d j%0d: got %b want 1", r, j, ir3); end
        iv3 = 1; id3 = 32'hA00 + 32'(r * 16 + j);
        @(negedge CLK);
      end
      iv3 = 0;
      n_chk++; if (ir3 !== 1'b0 || occ3 !== 2'd3) begin n_fail++; $display("FAIL wrap_full r%0d: got ready=%b occ=%0d want 0/3", r, ir3, occ3); end
      for (int j = 0; j < 3; j++) begin
        n_chk++; if (ov3 !== 1'b1 || od3 !== 32'hA00 + 32'(r * 16 + j)) begin n_fail++; $display("FAIL wrap_out r%0d j%0d: got valid=%b data=%h want 1/%h", r, j, ov3, od3, 32'hA00 + 32'(r * 16 + j)); end
        or3 = 1;
        @(negedge CLK);
      end
      or3 = 0;
      n_chk++; if (ov3 !== 1'b0 || occ3 !== 2'd0) begin n_fail++; $display("FAIL wrap_empty r%0d: got valid=%b occ=%0d want 0/0", r, ov3, occ3); end
    end
  endtask

  task automatic test_full_pop();
    or3 = 0;
    for (int j = 0; j < 3; j++) begin
      iv3 = 1; id3 = 32'hC0 + 32'(j);
      @(negedge CLK);
    end
    id3 = 32'hCC; or3 = 1;
    n_chk++; if (ir3 !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready_low: got %b want 0", ir3); end
    @(negedge CLK);
    n_chk++; if (occ3 !== 2'd2 || ir3 !== 1'b1) begin n_fail++; $display("FAIL fullpop_after: got occ=%0d ready=%b want 2/1", occ3, ir3); end
    n_chk++; if (od3 !== 32'hC1) begin n_fail++; $display("FAIL fullpop_head: got %h want c1", od3); end
    @(negedge CLK);
    iv3 = 0;
    n_chk++; if (od3 !== 32'hC2 || occ3 !== 2'd2) begin n_fail++; $display("FAIL fullpop_c2: got data=%h occ=%0d want c2/2", od3, occ3); end
    @(negedge CLK);
    n_chk++; if (od3 !== 32'hCC || occ3 !== 2'd1) begin n_fail++; $display("FAIL fullpop_cc: got data=%h occ=%0d want cc/1", od3, occ3); end
    @(negedge CLK);
    or3 = 0;
    n_chk++; if (occ3 !== 2'd0) begin n_fail++; $display("FAIL fullpop_empty: got %0d want 0", occ3); end
  endtask

  task automatic test_flush();
    do_reset();
    or3 = 0;
    iv3 = 1; id3 = 32'hE0;
    @(negedge CLK);
    id3 = 32'hE1;
    @(negedge CLK);
    n_chk++; if (occ3 !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 2", occ3); end
    id3 = 32'hD; or3 = 1; f3 = 1;
    n_chk++; if (ov3 !== 1'b1 || od3 !== 32'hE0 || ir3 !== 1'b1) begin n_fail++; $display("FAIL flush_head: got valid=%b data=%h ready=%b want 1/e0/1", ov3, od3, ir3); end
    @(negedge CLK);
    f3 = 0; iv3 = 0; or3 = 0;
    n_chk++; if (ov3 !== 1'b0 || ir3 !== 1'b1 || occ3 !== 2'd0) begin n_fail++; $display("FAIL flush_after: got valid=%b ready=%b occ=%0d want 0/1/0", ov3, ir3, occ3); end
`ifdef PIPE_STAT_EN
    n_chk++; if (fc3 !== 32'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d want 1", fc3); end
`endif
    f3 = 1;
    @(negedge CLK);
    f3 = 0;
`ifdef PIPE_STAT_EN
    n_chk++; if (fc3 !== 32'd1) begin n_fail++; $display("FAIL flush_cnt_empty: got %0d want 1", fc3); end
`endif
    iv3 = 1; id3 = 32'hF00D;
    @(negedge CLK);
    iv3 = 0;
    n_chk++; if (od3 !== 32'hF00D || occ3 !== 2'd1) begin n_fail++; $display("FAIL flush_repush: got data=%h occ=%0d want f00d/1", od3, occ3); end
    or3 = 1;
    @(negedge CLK);
    or3 = 0;
  endtask

  task automatic test_stall_and_async_reset();
    do_reset();
    or2 = 0; iv2 = 1; id2 = 32'h5;
    @(negedge CLK);
    iv2 = 0;
    repeat (5) @(negedge CLK);
`ifdef PIPE_STAT_EN
    n_chk++; if (sc2 !== 32'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d want 5", sc2); end
`endif
    n_chk++; if (ov2 !== 1'b1 || od2 !== 32'h5) begin n_fail++; $display("FAIL pre_rst_hold: got valid=%b data=%h want 1/5", ov2, od2); end
    #2 RST = 1'b1;
    #1;
    n_chk++; if (ov2 !== 1'b0 || occ2 !== 2'd0 || ir2 !== 1'b1) begin n_fail++; $display("FAIL async_rst: got valid=%b occ=%0d ready=%b want 0/0/1", ov2, occ2, ir2); end
    n_chk++; if (od2 !== 32'h0) begin n_fail++; $display("FAIL async_rst_data: got %h want 0", od2); end
`ifdef PIPE_STAT_EN
    n_chk++; if (sc2 !== 32'd0) begin n_fail++; $display("FAIL async_rst_stall: got %0d want 0", sc2); end
`endif
    @(negedge CLK);
    RST = 1'b0;
    iv2 = 1; id2 = 32'h77;
    @(negedge CLK);
    iv2 = 0;
    n_chk++; if (ov2 !== 1'b1 || od2 !== 32'h77) begin n_fail++; $display("FAIL post_rst_push: got valid=%b data=%h want 1/77", ov2, od2); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_fill_wrap();
    test_full_pop();
    test_flush();
    test_stall_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
